input_conditioner: RTL

//  Front-end stage between the eurorack pmod codec and network.sample_in0..3; one update per sample_clk edge.
//  Per channel: arithmetic pre-shift, DC-offset removal (offsets measured by a calibration FSM), saturation,
//  and click-free gain fade driven by jack-detect bits. Output feeds the network's left shift buffers directly.

---
 rtl/input_cond_pkg.sv | 33 +++
 rtl/input_cond_if.sv | 31 +++
 rtl/input_cond_channel.sv | 101 ++++++++++
 rtl/input_conditioner.sv | 132 +++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared types, defaults and helpers for the input_conditioner front end.
// Optional calibration is enabled by defining INPUT_COND_CAL_EN.
package input_cond_pkg;

    localparam int N_CH          = 4;
    localparam int DEF_W         = 16;
    localparam int DEF_PRE_SHIFT = 2;
    localparam int DEF_CAL_LOG2  = 6;
    localparam int DEF_FADE_LOG2 = 4;
    localparam int FADE_FULL     = 2 ** DEF_FADE_LOG2;
    localparam int CAL_N         = 2 ** DEF_CAL_LOG2;

    typedef enum logic {
        CAL,
        RUN
    } cond_state_e;

    // Clamp a signed value to the range of a w-bit two's complement number (w <= 32).
    function automatic logic signed [31:0] sat_w(input logic signed [32:0] v, input int w);
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi[31:0];
        end else if (v < lo) begin
            return lo[31:0];
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

// File: rtl/input_cond_if.sv
// Sample bus between the codec side (master) and the input_conditioner (slave).
// Calibration signals are present in every build; INPUT_COND_CAL_EN decides whether they act.
interface input_cond_if
    import input_cond_pkg::*;
#(
    parameter int W = DEF_W
);
    logic                cal_req;
    logic [7:0]          jack;
    logic signed [W-1:0] sample_in0;
    logic signed [W-1:0] sample_in1;
    logic signed [W-1:0] sample_in2;
    logic signed [W-1:0] sample_in3;
    logic signed [W-1:0] sample_out0;
    logic signed [W-1:0] sample_out1;
    logic signed [W-1:0] sample_out2;
    logic signed [W-1:0] sample_out3;
    logic                out_valid;
    logic                cal_busy;

    modport master (
        output cal_req, jack, sample_in0, sample_in1, sample_in2, sample_in3,
        input  sample_out0, sample_out1, sample_out2, sample_out3, out_valid, cal_busy
    );

    modport slave (
        input  cal_req, jack, sample_in0, sample_in1, sample_in2, sample_in3,
        output sample_out0, sample_out1, sample_out2, sample_out3, out_valid, cal_busy
    );

endinterface

// File: rtl/input_cond_channel.sv
// One conditioning lane: pre-shift, offset removal with saturation, gain fade, output register.
// With INPUT_COND_CAL_EN the lane also accumulates its own DC offset during calibration;
// without it the offset is fixed at zero.
module input_cond_channel
    import input_cond_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int PRE_SHIFT = DEF_PRE_SHIFT,
`ifdef INPUT_COND_CAL_EN
    parameter int CAL_LOG2  = DEF_CAL_LOG2,
`endif
    parameter int FADE_LOG2 = DEF_FADE_LOG2
) (
    input  logic                sample_clk,
    input  logic                rst,
`ifdef INPUT_COND_CAL_EN
    input  logic                cal_active,  // calibrating: accumulate y0
    input  logic                cal_done,    // last calibration edge: latch offset
`endif
    input  logic                hold,        // force gain and output to zero this edge
    input  logic                jack_on,     // fade target: full gain when set, silence when clear
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);

    localparam int P_W = W + FADE_LOG2 + 1;
    localparam logic [FADE_LOG2:0] G_ONE  = (FADE_LOG2 + 1)'(1);
    localparam logic [FADE_LOG2:0] G_FULL = G_ONE << FADE_LOG2;

    logic signed [W-1:0]  y0;
    logic signed [W-1:0]  y1;
    logic signed [W-1:0]  y_d;
    logic signed [W-1:0]  off_q;
    logic signed [W:0]    diff;
    logic signed [32:0]   diff_ext;
    logic signed [P_W-1:0] prod;
    logic [FADE_LOG2:0]   g_q;
    logic [FADE_LOG2:0]   g_d;

    assign y0       = x >>> PRE_SHIFT;
    // One extra bit so the subtraction itself can never wrap before clamping.
    assign diff     = {y0[W-1], y0} - {off_q[W-1], off_q};
    assign diff_ext = 33'(diff);
    assign y1       = W'(sat_w(diff_ext, W));

    // Gain walks one step per edge toward its target, so a jack change mid-fade just reverses direction.
    always_comb begin
        // NOTE: default assignment first, so no path leaves g_d unassigned and no latch is inferred.
        g_d = g_q;
        if (hold) begin
            g_d = '0;
        end else if (jack_on && (g_q != G_FULL)) begin
            g_d = g_q + G_ONE;
        end else if (!jack_on && (g_q != '0)) begin
            g_d = g_q - G_ONE;
        end
    end

    // The output uses the gain as stepped on this same edge.
    assign prod = P_W'(y1) * P_W'($signed({1'b0, g_d}));
    assign y_d  = hold ? '0 : W'(prod >>> FADE_LOG2);

    // Gain and output registers.
    always_ff @(posedge sample_clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks, so every register sees pre-edge values.
        if (rst) begin
            g_q <= '0;
            y   <= '0;
        end else begin
            g_q <= g_d;
            y   <= y_d;
        end
    end

`ifdef INPUT_COND_CAL_EN
    localparam int ACC_W = W + CAL_LOG2;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;

    assign acc_sum = acc_q + ACC_W'(y0);

    // Offset accumulation; the old offset stays in use until a calibration completes.
    always_ff @(posedge sample_clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            off_q <= '0;
        end else if (cal_done) begin
            off_q <= W'(acc_sum >>> CAL_LOG2);
            acc_q <= '0;
        end else if (cal_active) begin
            acc_q <= acc_sum;
        end else begin
            acc_q <= '0;
        end
    end
`else
    assign off_q = '0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Four-channel codec front end feeding the network's sample inputs.
// Define INPUT_COND_CAL_EN to build the offset-calibration FSM; without it offsets are zero,
// the block starts in RUN and cal_req is ignored.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int PRE_SHIFT = DEF_PRE_SHIFT,
    parameter int CAL_LOG2  = $clog2(CAL_N),
    parameter int FADE_LOG2 = $clog2(FADE_FULL)
) (
    input  logic         sample_clk,
    input  logic         rst,
    input_cond_if.slave  bus
);

    logic signed [W-1:0] x_arr [N_CH];
    logic signed [W-1:0] y_arr [N_CH];
    logic                hold;
    logic [3:0]          unused_jack_hi;

    assign x_arr[0] = bus.sample_in0;
    assign x_arr[1] = bus.sample_in1;
    assign x_arr[2] = bus.sample_in2;
    assign x_arr[3] = bus.sample_in3;

    assign bus.sample_out0 = y_arr[0];
    assign bus.sample_out1 = y_arr[1];
    assign bus.sample_out2 = y_arr[2];
    assign bus.sample_out3 = y_arr[3];

    // Only the low four jack bits map to channels.
    assign unused_jack_hi = bus.jack[7:4];

`ifdef INPUT_COND_CAL_EN
    localparam logic [CAL_LOG2-1:0] CNT_LAST = '1;
    localparam logic [CAL_LOG2-1:0] CNT_ONE  = CAL_LOG2'(1);

    cond_state_e         state_q;
    cond_state_e         state_d;
    logic [CAL_LOG2-1:0] cnt_q;
    logic [CAL_LOG2-1:0] cnt_d;
    logic                cal_active;
    logic                cal_done;

    // FSM state and calibration sample counter.
    always_ff @(posedge sample_clk or posedge rst) begin
        if (rst) begin
            state_q <= CAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // CAL counts samples until the last one; RUN re-enters CAL on a request (ignored while calibrating).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CAL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (bus.cal_req) begin
                    state_d = CAL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CAL;
                cnt_d   = '0;
            end
        endcase
    end

    assign cal_active    = (state_q == CAL);
    assign cal_done      = cal_active && (cnt_q == CNT_LAST);
    // Outputs are muted for the whole calibration and on the RUN edge that requests it.
    assign hold          = cal_active || bus.cal_req;
    assign bus.cal_busy  = cal_active;
    assign bus.out_valid = (state_q == RUN);
`else
    logic        valid_q;
    logic        unused_cal_req;
    logic [31:0] unused_cal_log2;

    // Valid rises on the first edge after reset and stays high.
    always_ff @(posedge sample_clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b1;
        end
    end

    assign hold            = 1'b0;
    assign bus.cal_busy    = 1'b0;
    assign bus.out_valid   = valid_q;
    assign unused_cal_req  = bus.cal_req;
    assign unused_cal_log2 = CAL_LOG2;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        input_cond_channel #(
            .W         (W),
            .PRE_SHIFT (PRE_SHIFT),
`ifdef INPUT_COND_CAL_EN
            .CAL_LOG2  (CAL_LOG2),
`endif
            .FADE_LOG2 (FADE_LOG2)
        ) u_ch (
            .sample_clk (sample_clk),
            .rst        (rst),
`ifdef INPUT_COND_CAL_EN
            .cal_active (cal_active),
            .cal_done   (cal_done),
`endif
            .hold       (hold),
            .jack_on    (bus.jack[i]),
            .x          (x_arr[i]),
            .y          (y_arr[i])
        );
    end

endmodule
